// File: rtl/hit_judge.sv
// Per-frame collision judge: counts boss/player overlap pixels, owns lives, invincibility and game over.
// Optional player blink during invincibility is enabled by defining HIT_JUDGE_BLINK_EN.
module hit_judge #(
  parameter int LIVES_INIT    = 3,
  parameter int INVINC_FRAMES = 120,
  parameter int MIN_OVERLAP   = 4,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       frame_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       moon_on,
  input  logic       player_on,
  input  logic       restart,
  output logic [2:0] lives,
  output logic       invincible,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       player_visible
);

  typedef enum logic [1:0] {ALIVE, INVINC, GAME_OVER} state_t;

  state_t      state;
  logic [11:0] ovl;
  logic [7:0]  inv_cnt;
  logic        qual;

  assign qual = pixel_tick && moon_on && player_on && (x < 10'd384) && (y < 10'd448);

  // A qualifying pixel on the frame_tick cycle already belongs to the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovl <= '0;
    end else if (frame_tick) begin
      ovl <= {11'd0, qual};
    end else if (qual && (ovl != 12'hfff)) begin
      ovl <= ovl + 12'd1;
    end
  end

`ifdef HIT_JUDGE_BLINK_EN
  logic [7:0] blink_cnt;
  logic       visible_q;
  assign player_visible = visible_q;
`else
  assign player_visible = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ALIVE;
      lives      <= 3'(LIVES_INIT);
      invincible <= 1'b0;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      inv_cnt    <= '0;
`ifdef HIT_JUDGE_BLINK_EN
      blink_cnt  <= '0;
      visible_q  <= 1'b1;
`endif
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        ALIVE: begin
          if (frame_tick && (ovl >= 12'(MIN_OVERLAP))) begin
            hit_pulse <= 1'b1;
            lives     <= lives - 3'd1;
            if (lives == 3'd1) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state      <= INVINC;
              invincible <= 1'b1;
              inv_cnt    <= 8'(INVINC_FRAMES);
`ifdef HIT_JUDGE_BLINK_EN
              blink_cnt  <= '0;
              visible_q  <= 1'b0;
`endif
            end
          end
        end
        INVINC: begin
          if (frame_tick) begin
            if (inv_cnt == 8'd1) begin
              state      <= ALIVE;
              invincible <= 1'b0;
              inv_cnt    <= '0;
`ifdef HIT_JUDGE_BLINK_EN
              blink_cnt  <= '0;
              visible_q  <= 1'b1;
`endif
            end else begin
              inv_cnt <= inv_cnt - 8'd1;
`ifdef HIT_JUDGE_BLINK_EN
              if (blink_cnt == 8'(BLINK_PERIOD - 1)) begin
                blink_cnt <= '0;
                visible_q <= ~visible_q;
              end else begin
                blink_cnt <= blink_cnt + 8'd1;
              end
`endif
            end
          end
        end
        GAME_OVER: begin
          if (restart) begin
            state      <= INVINC;
            lives      <= 3'(LIVES_INIT);
            game_over  <= 1'b0;
            invincible <= 1'b1;
            inv_cnt    <= 8'(INVINC_FRAMES);
`ifdef HIT_JUDGE_BLINK_EN
            blink_cnt  <= '0;
            visible_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= ALIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: a frame-level behavioural model checked every cycle plus literal pins.
module tb_hit_judge;
  localparam int LI   = 3;
  localparam int INV  = 120;
  localparam int MINO = 4;
  localparam int BP   = 8;
`ifdef HIT_JUDGE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_tick = 1'b0, frame_tick = 1'b0, moon_on = 1'b0, player_on = 1'b0, restart = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [2:0] lives;
  logic       invincible, game_over, hit_pulse, player_visible;

  hit_judge #(.LIVES_INIT(LI), .INVINC_FRAMES(INV), .MIN_OVERLAP(MINO), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
    .x(x), .y(y), .moon_on(moon_on), .player_on(player_on), .restart(restart),
    .lives(lives), .invincible(invincible), .game_over(game_over),
    .hit_pulse(hit_pulse), .player_visible(player_visible));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, hits_seen = 0;

  // Model: mode 0 = alive, 1 = invincible, 2 = game over.
  int m_mode = 0, m_lives = LI, m_ovl = 0, m_inv_frames = 0;
  bit m_hit = 1'b0;

  function automatic bit m_visible();
    if (m_mode != 1 || !BLINK) return 1'b1;
    return ((m_inv_frames / BP) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lives = LI; m_ovl = 0; m_inv_frames = 0; m_hit = 1'b0;
  endtask

  task automatic model_edge();
    bit q;
    q = pixel_tick && moon_on && player_on && (x < 384) && (y < 448);
    m_hit = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_mode == 2 && restart) begin
      m_mode = 1; m_lives = LI; m_inv_frames = 0;
    end else if (frame_tick) begin
      if (m_mode == 0 && m_ovl >= MINO) begin
        m_hit = 1'b1;
        m_lives = m_lives - 1;
        m_mode = (m_lives == 0) ? 2 : 1;
        m_inv_frames = 0;
      end else if (m_mode == 1) begin
        m_inv_frames++;
        if (m_inv_frames == INV) m_mode = 0;
      end
    end
    if (frame_tick) m_ovl = q ? 1 : 0;
    else if (q) m_ovl = (m_ovl >= 4095) ? 4095 : m_ovl + 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("lives", int'(lives), m_lives);
    chk("invincible", int'(invincible), int'(m_mode == 1));
    chk("game_over", int'(game_over), int'(m_mode == 2));
    chk("hit_pulse", int'(hit_pulse), int'(m_hit));
    chk("player_visible", int'(player_visible), int'(m_visible()));
    if (hit_pulse) hits_seen++;
  end

  task automatic cyc(input bit pt, input bit mo, input bit pl, input int xx, input int yy,
                     input bit ft, input bit rs);
    pixel_tick = pt; moon_on = mo; player_on = pl; x = 10'(xx); y = 10'(yy);
    frame_tick = ft; restart = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic overlap(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 1, 100 + (i % 200), 50, 0, 0);
  endtask

  task automatic ftick();
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(1);
  endtask

  initial begin
    #1;
    idle(3);
    reset = 1'b0;
    idle(2);
    chk("reset_lives", int'(lives), 3);
    chk("reset_visible", int'(player_visible), 1);
    chk("reset_state", int'({invincible, game_over, hit_pulse}), 0);

    // Below threshold: no hit.
    overlap(3); ftick();
    chk("below_min_lives", int'(lives), 3);
    chk("below_min_hits", hits_seen, 0);

    // Pixels outside the field, without pixel_tick, or single-sprite are not counted.
    cyc(1, 1, 1, 384, 10, 0, 0);
    cyc(1, 1, 1, 10, 448, 0, 0);
    cyc(0, 1, 1, 10, 10, 0, 0);
    cyc(1, 1, 0, 10, 10, 0, 0);
    cyc(1, 0, 1, 10, 10, 0, 0);
    overlap(3); ftick();
    chk("out_of_field_hits", hits_seen, 0);

    // Pixel coincident with frame_tick carries into the next frame.
    overlap(3);
    cyc(1, 1, 1, 20, 20, 1, 0);
    idle(1);
    chk("coincident_not_judged", hits_seen, 0);
    overlap(3); ftick();
    chk("carry_hit_count", hits_seen, 1);
    chk("carry_hit_lives", int'(lives), 2);
    chk("carry_hit_invinc", int'(invincible), 1);

    // Invincibility: heavy overlap ignored, exactly INV frames long.
    for (int f = 1; f <= INV; f++) begin
      overlap(6); ftick();
      if (f == BP) chk("blink_after_bp", int'(player_visible), BLINK ? 1 : 1);
      if (f == BP - 1) chk("blink_before_bp", int'(player_visible), BLINK ? 0 : 1);
      if (f == INV - 1) chk("invinc_last_frame", int'(invincible), 1);
    end
    chk("invinc_over", int'(invincible), 0);
    chk("invinc_visible", int'(player_visible), 1);
    chk("invinc_no_loss", int'(lives), 2);

    // First frame back in ALIVE can register a hit.
    overlap(4); ftick();
    chk("second_hit_lives", int'(lives), 1);
    for (int f = 0; f < INV; f++) ftick();

    // Saturating count: one hit only, final life.
    overlap(5000); ftick();
    chk("sat_hit_count", hits_seen, 3);
    chk("sat_lives", int'(lives), 0);
    chk("sat_game_over", int'(game_over), 1);
    overlap(10); ftick();
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("game_over_holds", hits_seen, 3);

    // Restart wins over a simultaneous frame_tick.
    cyc(0, 0, 0, 0, 0, 1, 1);
    idle(1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_invinc", int'(invincible), 1);
    chk("restart_go", int'(game_over), 0);
    for (int f = 0; f < 10; f++) ftick();

    // Async reset mid-invincibility.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_lives", int'(lives), 3);
    chk("async_rst_invinc", int'(invincible), 0);
    chk("async_rst_visible", int'(player_visible), 1);
    model_reset();
    idle(2);
    reset = 1'b0;

    // Restart in ALIVE is ignored; pixels before a reset are discarded.
    cyc(0, 0, 0, 0, 0, 0, 1);
    overlap(3);
    #2 reset = 1'b1;
    #1 model_reset();
    idle(1);
    reset = 1'b0;
    overlap(3); ftick();
    chk("post_reset_no_hit", hits_seen, 3);
    overlap(1); ftick();
    chk("post_reset_alive", int'(invincible), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got time %0t expected < 2000000", $time);
    $fatal(1);
  end
endmodule

// File: doc/hit_judge.md
# hit_judge

Per-frame collision judge downstream of the boss sprite (`moon`) and the player sprite renderers. It counts pixels where `moon_on` and `player_on` overlap inside the 384×448 play field and evaluates the count once per frame. It owns the player's life counter, post-hit invincibility window and game-over state, and drives the player-blink enable consumed by the pixel compositor.

## Interface
Parameters:
- `LIVES_INIT`, 3 — lives after reset/restart; range 1..7.
- `INVINC_FRAMES`, 120 — frames of invincibility after a hit or restart; range 1..255.
- `MIN_OVERLAP`, 4 — overlapping pixels in one frame needed to register a hit; range 1..4095.
- `BLINK_PERIOD`, 8 — frames per blink half-cycle during invincibility; range 1..255.

Ports:
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-high.
- `pixel_tick` in 1 — pixel enable, one `clk` per pixel.
- `frame_tick` in 1 — one-`clk` pulse at the start of vertical blank.
- `x`, `y` in 10 each — current pixel coordinate.
- `moon_on` in 1 — boss sprite opaque at (`x`, `y`).
- `player_on` in 1 — player hitbox pixel at (`x`, `y`).
- `restart` in 1 — one-`clk` pulse; honoured only in GAME_OVER.
- `lives` out 3 — remaining lives.
- `invincible` out 1 — high in INVINC.
- `game_over` out 1 — high in GAME_OVER.
- `hit_pulse` out 1 — one-`clk` pulse per registered hit.
- `player_visible` out 1 — gates the player sprite in the compositor.

## Operation
- Overlap counter `ovl` is 12 bits and saturates at 4095.
  - Increments when `pixel_tick && moon_on && player_on && x<384 && y<448`.
  - Counting is active in every state.
- Evaluation happens on the `frame_tick` edge and uses the `ovl` value from before that edge. On the same edge `ovl` is reloaded:
  - to 1 if a qualifying overlap pixel coincides with `frame_tick` (that pixel belongs to the next frame);
  - to 0 otherwise.
- FSM states: ALIVE, INVINC, GAME_OVER.
  - ALIVE: at `frame_tick` with `ovl>=MIN_OVERLAP`:
    - `hit_pulse` fires and `lives` decrements.
    - If `lives` was 1, go to GAME_OVER (`lives`=0).
    - Otherwise go to INVINC with `inv_cnt`=INVINC_FRAMES and `blink_cnt`=0.
  - INVINC: overlap is ignored.
    - Each `frame_tick` decrements `inv_cnt`.
    - At a `frame_tick` where `inv_cnt`==1, go to ALIVE. That frame's overlap is not evaluated.
  - GAME_OVER: `ovl` is ignored.
    - `restart` sets `lives`=LIVES_INIT and enters INVINC with a full `inv_cnt`.
    - `restart` in any other state is ignored.
- If `restart` and `frame_tick` arrive in the same cycle, `restart` wins.
- `player_visible`:
  - Always 1 outside INVINC.
  - In INVINC it follows the blink rule under Configuration.
- `pixel_tick` is not required for `frame_tick` or `restart` handling.

## Timing
- Reset values: `lives`=LIVES_INIT, state ALIVE, `invincible`=0, `game_over`=0, `hit_pulse`=0, `player_visible`=1, `ovl`=0, `inv_cnt`=0, `blink_cnt`=0.
- All outputs are registered. State, `lives` and `hit_pulse` change on the `clk` edge that samples `frame_tick` and are visible one cycle after it.
- `hit_pulse` is high for exactly one cycle. At most one hit is registered per frame.
- Reset asserted mid-frame or mid-invincibility returns everything to reset values immediately. The first evaluation after release uses only pixels counted after release.
- Invincibility lasts exactly INVINC_FRAMES `frame_tick`s.
- A hit can first be registered at the `frame_tick` after the one that returned the FSM to ALIVE.

## Configuration
- `HIT_JUDGE_BLINK_EN` defined:
  - In INVINC, `blink_cnt` counts `frame_tick`s modulo BLINK_PERIOD.
  - `player_visible` toggles each time `blink_cnt` wraps. It starts at 0 on entry to INVINC.
  - It is forced to 1 on leaving INVINC.
- `HIT_JUDGE_BLINK_EN` undefined:
  - `player_visible` is tied to 1.
  - `blink_cnt` logic is not synthesised.
  - All other behaviour is identical.

## Test plan
- 3 overlap pixels in a frame, MIN_OVERLAP=4, then `frame_tick` → no `hit_pulse`, `lives`=3, state ALIVE.
- 4 overlap pixels, then `frame_tick` → `hit_pulse` for 1 cycle, `lives`=2, `invincible`=1. After 120 further `frame_tick`s `invincible`=0. Heavy overlap during INVINC never decrements `lives`.
- Three separated hits → `lives`=0 and `game_over`=1. Then `restart` → `lives`=3, `invincible`=1, `game_over`=0.
- Overlap pixel at x=384 or y=448, and overlap with `pixel_tick`=0 → not counted. 5000 overlap pixels → `ovl` saturates at 4095 and a hit is registered once.
- Overlap pixel coincident with `frame_tick` (MIN_OVERLAP=1, state ALIVE) → not judged in the current frame; a hit is registered at the next `frame_tick`. Also: `reset` pulsed mid-INVINC → all outputs return to reset values asynchronously.
- With `HIT_JUDGE_BLINK_EN`, BLINK_PERIOD=8: after a hit, `player_visible` is 0 for 8 frames, then 1 for 8 frames, and is 1 after INVINC ends. Without the macro it stays 1 throughout.
